// File: rtl/rename_register_file_if.sv
// rename_register_file_if: dispatch/commit/read bundle for the rename register file.
// Rev 1.0
`default_nettype none

interface rename_register_file_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int TAG_W    = 4,
  parameter int NUM_RD   = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_RD*TAG_W-1:0]  rd_tag;
  logic                     ren_en;
  logic [ADDR_W-1:0]        ren_reg;
  logic [TAG_W-1:0]         ren_tag;
  logic                     commit_en;
  logic [ADDR_W-1:0]        commit_reg;
  logic [TAG_W-1:0]         commit_tag;
  logic [DATA_W-1:0]        commit_data;
  logic                     flush;
  logic [ADDR_W:0]          busy_count;

  modport master (
    output rd_addr, ren_en, ren_reg, ren_tag,
    output commit_en, commit_reg, commit_tag, commit_data, flush,
    input  rd_data, rd_busy, rd_tag, busy_count
  );

  modport slave (
    input  rd_addr, ren_en, ren_reg, ren_tag,
    input  commit_en, commit_reg, commit_tag, commit_data, flush,
    output rd_data, rd_busy, rd_tag, busy_count
  );
endinterface

`default_nettype wire

// File: rtl/rename_register_file.sv
// rename_register_file: architectural registers with busy/ROB-tag rename status and commit bypass.
// Rev 1.0
`default_nettype none

module rename_register_file #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int TAG_W    = 4,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  rename_register_file_if.slave rf
);

  logic [DATA_W-1:0]   data_q [NUM_REGS];
  logic [DATA_W-1:0]   data_d [NUM_REGS];
  logic [TAG_W-1:0]    tag_q  [NUM_REGS];
  logic [TAG_W-1:0]    tag_d  [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W:0]     count_d;

  // Commit releases only when its tag still owns the register; rename then
  // overrides, and flush suppresses the rename and clears every busy bit.
  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (rf.commit_en) begin
      data_d[rf.commit_reg] = rf.commit_data;
      if (busy_q[rf.commit_reg] && (tag_q[rf.commit_reg] == rf.commit_tag)) begin
        busy_d[rf.commit_reg] = 1'b0;
      end
    end
    if (rf.ren_en && !rf.flush) begin
      busy_d[rf.ren_reg] = 1'b1;
      tag_d[rf.ren_reg]  = rf.ren_tag;
    end
    if (rf.flush) begin
      busy_d = '0;
    end
    if (ZERO_REG) begin
      data_d[0] = '0;
      tag_d[0]  = '0;
      busy_d[0] = 1'b0;
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      count_d = count_d + (ADDR_W+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      tag_q   <= tag_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  logic [ADDR_W-1:0] rd_a   [NUM_RD];
  logic [NUM_RD-1:0] rd_hit;
  logic [NUM_RD-1:0] rd_zero;

  // Read side sees committed state plus the same-cycle commit; never the rename.
  always_comb begin
    rf.rd_data = '0;
    rf.rd_busy = '0;
    rf.rd_tag  = '0;
    rd_hit     = '0;
    rd_zero    = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_a[i]    = rf.rd_addr[i*ADDR_W +: ADDR_W];
      rd_hit[i]  = rf.commit_en && (rf.commit_reg == rd_a[i]);
      rd_zero[i] = ZERO_REG && (rd_a[i] == '0);
      if (!rd_zero[i]) begin
        rf.rd_data[i*DATA_W +: DATA_W] = rd_hit[i] ? rf.commit_data : data_q[rd_a[i]];
        rf.rd_busy[i] = busy_q[rd_a[i]] && !(rd_hit[i] && (rf.commit_tag == tag_q[rd_a[i]]));
        rf.rd_tag[i*TAG_W +: TAG_W] = tag_q[rd_a[i]];
      end
    end
  end

  assign rf.busy_count = count_q;

endmodule

`default_nettype wire

// File: doc/rename_register_file.md
# rename_register_file

Parametrised architectural register file with integrated rename status (busy bit plus ROB tag per register) for the Tomasulo core. Dispatch reads source operands and either gets a value or the ROB tag to wait on. Dispatch also claims a destination register for a new ROB tag. ROB commit writes values back and releases the claim only when the committing tag is still the current owner.

## Interface
Parameters:
- DATA_W, 16, register data width
- NUM_REGS, 32, number of architectural registers (power of two, ≥ 2)
- ADDR_W, $clog2(NUM_REGS), register address width
- TAG_W, 4, ROB tag width
- NUM_RD, 2, number of read ports
- ZERO_REG, 1, when 1 register 0 reads as 0, is never busy, and ignores writes and renames

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read values (combinational)
- rd_busy  out  NUM_RD  1 = value pending; consumer waits on rd_tag
- rd_tag  out  NUM_RD*TAG_W  owning ROB tag (valid when rd_busy = 1)
- ren_en  in  1  claim destination register
- ren_reg  in  ADDR_W  destination register
- ren_tag  in  TAG_W  ROB tag of the new owner
- commit_en  in  1  ROB commit strobe
- commit_reg  in  ADDR_W  committed register
- commit_tag  in  TAG_W  ROB tag of the committing entry
- commit_data  in  DATA_W  committed value
- flush  in  1  misprediction recovery; clears all busy bits
- busy_count  out  ADDR_W+1  registered count of busy registers

## Operation
- State per register: data[DATA_W], busy, tag[TAG_W].
- Reset (reset_n low, asynchronous): all data, busy and tag cleared; busy_count = 0. Read outputs then show 0 / not busy / tag 0.
- Commit write: if commit_en, data[commit_reg] <= commit_data unconditionally, including stale tags, since in-order commit makes it architecturally correct.
- Commit release: busy[commit_reg] <= 0 only if busy is set and tag[commit_reg] == commit_tag. A mismatch means a younger rename owns the register, so busy and tag stay unchanged.
- Rename: if ren_en, busy[ren_reg] <= 1 and tag[ren_reg] <= ren_tag.
- Rename and commit in the same cycle to the same register: data is written; rename wins, so busy = 1 and tag = ren_tag.
- Flush: every busy bit <= 0 next edge, and flush overrides a same-cycle rename. Same-cycle commit data is still written. Tags are left unchanged (don't-care while not busy).
- ZERO_REG = 1 and address 0: writes and renames are ignored; reads return data 0, busy 0, tag 0.
- Read port i, address a (combinational):
  - rd_data = commit_data when commit_en and commit_reg == a; otherwise data[a]. This is the write-through bypass.
  - rd_busy = busy[a], except forced 0 when commit_en, commit_reg == a and commit_tag == tag[a].
  - rd_tag = tag[a].
  - A same-cycle rename is never visible to reads. An instruction's sources therefore never see its own destination claim.
- busy_count: registered population count of the next-state busy vector. It is 0 after reset and 0 the cycle after flush.

## Timing
- Read: 0-cycle combinational latency.
- Commit, rename and flush effects appear on reads in the cycle after the edge. Commit is also visible through the bypass in its own cycle.
- Any number of read ports may alias the same register and the commit/rename addresses; all see identical values.
- Out-of-range addresses cannot occur because NUM_REGS = 2^ADDR_W.
- reset_n assertion mid-operation clears state immediately, without waiting for clk. The first update after deassertion occurs on the next rising edge.

## Test plan
- Reset then read: assert reset_n = 0, release, read r5 and r31 → data 0, busy 0, busy_count 0.
- Rename then commit with bypass: rename r3 tag 7; next cycle read r3 → busy 1, tag 7. Commit r3 tag 7 data 16'hBEEF; same cycle read r3 → data BEEF, busy 0. Next cycle: busy 0, busy_count 0.
- Stale commit: rename r4 tag 2, then rename r4 tag 9, then commit r4 tag 2 data 16'h1111 → data reads 1111, busy 1, tag 9, busy_count 1.
- Same-cycle collision: r6 busy tag 3; in one cycle commit r6 tag 3 data 16'h00AA and rename r6 tag 5 → next cycle data 00AA, busy 1, tag 5.
- Flush: rename r1, r2, r7 (busy_count 3); in one cycle assert flush with ren_en on r8 → next cycle all four busy 0, busy_count 0.
- Zero register and async reset: rename r0 and commit r0 data 16'hFFFF → r0 reads 0, not busy. Then pull reset_n low between edges with r3 = 16'h1234 → r3 reads 0 before the next clk edge.
